dot_product_accumulator: RTL and testbench
==========================================

// Module: dot_product_accumulator
// PURPOSE
//   Sequential wrapper around the team's combinational WIDTH-bit unsigned array multiplier.
//   - Registers each accepted operand pair and drives it onto the multiplier.
//   - Samples the 2*WIDTH-bit product and accumulates up to LENGTH products into one dot-product sum.
//   - Presents the sum on a valid/ready output port.
// PARAMETERS
//   WIDTH     6                         operand width; must match the multiplier instance
//   LENGTH    8                         max pairs per dot product (>=2)
//   ACCWIDTH  2*WIDTH+$clog2(LENGTH)    accumulator/sum width (15 at defaults)
//   CNTW      $clog2(LENGTH+1)          pair-count width (4 at defaults)
// PORTS
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         reset; synchronous, active-low
//   in_valid   in   1         operand pair valid
//   in_ready   out  1         block accepts a pair this cycle
//   in_q       in   WIDTH     multiplier operand
//   in_m       in   WIDTH     multiplicand operand
//   in_last    in   1         pair is the final element of the vector
//   mult_q     out  WIDTH     registered operand to the multiplier's q input
//   mult_m     out  WIDTH     registered operand to the multiplier's m input
//   mult_p     in   2*WIDTH   combinational product returned by the multiplier
//   out_valid  out  1         out_sum/out_count valid
//   out_ready  in   1         downstream accepts the result
//   out_sum    out  ACCWIDTH  dot-product sum, unsigned
//   out_count  out  CNTW      number of pairs in out_sum, 1..LENGTH
// BEHAVIOUR
//   - Reset (rst_n low at a rising edge):
//     - State goes to ACCUM; accumulator and count are cleared.
//     - mult_q, mult_m, stage-1 valid and stage-1 last flag are all cleared.
//     - Outputs: out_valid=0, out_sum=0, out_count=0, in_ready=1.
//     - A reset mid-vector or mid-HOLD discards all partial work. Reset has priority over every other event.
//   - Handshakes:
//     - Input handshake: in_valid && in_ready at a rising edge.
//     - Output handshake: out_valid && out_ready at a rising edge.
//   - Stage 1 (input handshake edge):
//     - mult_q<=in_q, mult_m<=in_m, v1<=1, last1<=final, where final = in_last || (count_accepted == LENGTH-1).
//     - With no input handshake, v1<=0 and mult_q/mult_m hold their values.
//   - Stage 2 (edge with v1=1):
//     - acc<=acc+zero-extended mult_p; out_count increments.
//     - mult_p is sampled one cycle after the operands were registered, so there is no combinational path from in_* to the accumulator.
//   - Width: ACCWIDTH holds LENGTH*(2^WIDTH-1)^2 exactly. No saturation and no wrap can occur.
//   - FSM states:
//     - ACCUM: in_ready=1. On an input handshake with final=1, go to FLUSH.
//     - FLUSH: in_ready=0. Stage 2 absorbs the last product; go to HOLD on the next edge.
//     - HOLD: in_ready=0, out_valid=1. out_sum and out_count stay stable until the output handshake. On that edge, clear acc and count and go to ACCUM.
//   - Latency:
//     - Final input handshake at edge E: out_valid is visible after edge E+2.
//     - Earliest next in_ready=1 is after the output-handshake edge.
//   - Throughput inside a vector: one pair per cycle. in_valid bubbles are allowed and do not change the result.
//   - in_last on the LENGTH-th pair is redundant and harmless.
//   - in_* are ignored whenever in_ready=0.
//   - out_ready while out_valid=0 has no effect.
// TESTING  (WIDTH=6, LENGTH=8)
//   1. rst_n=0 for 2 edges, then 1 -> out_valid=0, out_sum=0, in_ready=1, mult_q=mult_m=0.
//   2. 8 back-to-back pairs (63,63), out_ready=1 -> out_sum=31752, out_count=8, out_valid 2 edges after the 8th handshake.
//   3. Pairs (2,3),(4,5),(6,7) with in_last on the 3rd -> out_sum=68, out_count=3, in_ready=0 until the result is taken.
//   4. Result held with out_ready=0 for 5 cycles -> out_sum/out_valid stable and in_ready=0. Then a vector of 8x(1,1) -> out_sum=8 (acc cleared).
//   5. Pairs (5,9)x4 with 1-3 cycle in_valid gaps, last on the 4th -> out_sum=180, out_count=4.
//   6. rst_n=0 after 4 pairs of (10,10) -> all cleared. Then 8x(1,2) -> out_sum=16, out_count=8.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator around an external WIDTH-bit multiplier.
// Registers operands, accumulates products, holds the sum for a handshake.
module dot_product_accumulator #(
  parameter int WIDTH    = 6,
  parameter int LENGTH   = 8,
  parameter int ACCWIDTH = 2*WIDTH+$clog2(LENGTH),
  parameter int CNTW     = $clog2(LENGTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_q,
  input  logic [WIDTH-1:0]    in_m,
  input  logic                in_last,
  output logic [WIDTH-1:0]    mult_q,
  output logic [WIDTH-1:0]    mult_m,
  input  logic [2*WIDTH-1:0]  mult_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACCWIDTH-1:0] out_sum,
  output logic [CNTW-1:0]     out_count
);

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    HOLD
  } state_t;

  state_t state;
  state_t nextState;

  logic [ACCWIDTH-1:0] acc;
  logic [CNTW-1:0]     cnt;
  logic [CNTW-1:0]     acceptCnt;
  logic                v1;
  logic                last1;
  logic                inFire;
  logic                outFire;
  logic                isFinal;

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;
  assign isFinal = in_last ||
                   (acceptCnt == CNTW'(LENGTH-1));

  assign out_sum   = acc;
  assign out_count = cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= nextState;
  end

  // Next state and handshake outputs
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && isFinal)
          nextState = FLUSH;
      end
      FLUSH: begin
        if (!(v1 && last1))
          nextState = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          nextState = ACCUM;
      end
      default: nextState = ACCUM;
    endcase
  end

  // Stage 1: register accepted operands toward the multiplier
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mult_q <= '0;
      mult_m <= '0;
      v1     <= 1'b0;
      last1  <= 1'b0;
    end else if (inFire) begin
      mult_q <= in_q;
      mult_m <= in_m;
      v1     <= 1'b1;
      last1  <= isFinal;
    end else begin
      v1     <= 1'b0;
      last1  <= 1'b0;
    end
  end

  // Count of pairs accepted in the current vector
  always_ff @(posedge clk) begin
    if (!rst_n)      acceptCnt <= '0;
    else if (outFire) acceptCnt <= '0;
    else if (inFire)  acceptCnt <= acceptCnt + CNTW'(1);
  end

  // Stage 2: accumulate the product one cycle after registering
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (outFire) begin
      acc <= '0;
      cnt <= '0;
    end else if (v1) begin
      acc <= acc + ACCWIDTH'(mult_p);
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator.
// Directed and random vectors against an arithmetic dot-product model.
module tb_dot_product_accumulator;
  localparam int WIDTH    = 6;
  localparam int LENGTH   = 8;
  localparam int ACCWIDTH = 2*WIDTH+$clog2(LENGTH);
  localparam int CNTW     = $clog2(LENGTH+1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    in_q = '0;
  logic [WIDTH-1:0]    in_m = '0;
  logic                in_last = 1'b0;
  logic [WIDTH-1:0]    mult_q;
  logic [WIDTH-1:0]    mult_m;
  logic [2*WIDTH-1:0]  mult_p;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACCWIDTH-1:0] out_sum;
  logic [CNTW-1:0]     out_count;

  int nAsserts = 0;
  int nFail    = 0;
  logic keepReady = 1'b0;
  int qs[$];
  int ms[$];

  dot_product_accumulator #(
    .WIDTH(WIDTH),
    .LENGTH(LENGTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_q(in_q),
    .in_m(in_m),
    .in_last(in_last),
    .mult_q(mult_q),
    .mult_m(mult_m),
    .mult_p(mult_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count)
  );

  // Combinational array multiplier stand-in
  assign mult_p = (2*WIDTH)'(mult_q) * (2*WIDTH)'(mult_m);

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sendPair(input int q, input int m,
                          input logic last, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_q     = WIDTH'(q);
    in_m     = WIDTH'(m);
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_inReady"}, 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic runVector(input int lastAt, input int maxGap,
                           input int hold, input string tag);
    logic [63:0] expSum;
    int expCnt;
    int n;
    int gap;
    expSum = 0;
    expCnt = 0;
    for (int i = 0; i < qs.size(); i++) begin
      gap = (maxGap > 0 && i > 0) ? $urandom_range(maxGap, 1) : 0;
      if (maxGap < 0) gap = $urandom_range(2, 0);
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      sendPair(qs[i], ms[i], i == lastAt, tag);
      expSum += 64'(qs[i] * ms[i]);
      expCnt++;
      if (i == lastAt || expCnt == LENGTH) break;
    end
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      n++;
    end while (!out_valid && n < 12);
    check({tag, "_latency"}, 64'(n), 64'd3);
    check({tag, "_sum"}, 64'(out_sum), expSum);
    check({tag, "_count"}, 64'(out_count), 64'(expCnt));
    check({tag, "_inReadyLow"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_holdValid"}, 64'(out_valid), 64'd1);
      check({tag, "_holdSum"}, 64'(out_sum), expSum);
      check({tag, "_holdReady"}, 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_q     = WIDTH'($urandom_range(63, 0));
      in_m     = WIDTH'($urandom_range(63, 0));
      in_last  = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_takenValid"}, 64'(out_valid), 64'd0);
    check({tag, "_takenReady"}, 64'(in_ready), 64'd1);
    check({tag, "_takenSum"}, 64'(out_sum), 64'd0);
    out_ready = keepReady;
  endtask

  task automatic fill(input int n, input int q, input int m);
    qs.delete();
    ms.delete();
    for (int i = 0; i < n; i++) begin
      qs.push_back(q);
      ms.push_back(m);
    end
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstValid", 64'(out_valid), 64'd0);
    check("rstSum", 64'(out_sum), 64'd0);
    check("rstCount", 64'(out_count), 64'd0);
    check("rstReady", 64'(in_ready), 64'd1);
    check("rstMultQ", 64'(mult_q), 64'd0);
    check("rstMultM", 64'(mult_m), 64'd0);
    rst_n = 1'b1;

    keepReady = 1'b1;
    out_ready = 1'b1;
    fill(8, 63, 63);
    runVector(-1, 0, 0, "max");
    keepReady = 1'b0;
    out_ready = 1'b0;

    qs = '{2, 4, 6};
    ms = '{3, 5, 7};
    runVector(2, 0, 5, "short");

    fill(8, 1, 1);
    runVector(7, 0, 0, "ones");

    fill(4, 5, 9);
    runVector(3, 3, 0, "gaps");

    fill(4, 10, 10);
    for (int i = 0; i < 4; i++)
      sendPair(10, 10, 1'b0, "pre");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midRstSum", 64'(out_sum), 64'd0);
    check("midRstCount", 64'(out_count), 64'd0);
    check("midRstValid", 64'(out_valid), 64'd0);
    check("midRstReady", 64'(in_ready), 64'd1);
    check("midRstMultQ", 64'(mult_q), 64'd0);
    rst_n = 1'b1;
    fill(8, 1, 2);
    runVector(-1, 0, 0, "afterRst");

    repeat (8) begin
      len = $urandom_range(10, 1);
      qs.delete();
      ms.delete();
      for (int i = 0; i < len; i++) begin
        qs.push_back($urandom_range(63, 0));
        ms.push_back($urandom_range(63, 0));
      end
      runVector((len <= LENGTH) ? len - 1 : -1, -1,
                $urandom_range(3, 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
